// File: rtl/normalize_round.sv
// Post-add normalization and rounding stage of the FPU adder datapath.
// Takes the raw mantissa sum and the larger exponent chosen by the alignment
// front end, renormalizes (one right shift on carry, iterative left shifts on
// cancellation), rounds to nearest-even and packs an IEEE-754 result.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for an operand, previous result and flags still visible
// CHECK | classify the captured sum: zero, inf input, carry, normal, denormal
// SHIFT | one left shift per cycle until hidden bit set or denormal boundary
// ROUND | round-to-nearest-even, exponent fixup and packing
// DONE  | result valid, held until the consumer accepts it
module normalize_round #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           sign_in,
  input  logic [EXP_WIDTH-1:0]           exp_in,
  input  logic [MAN_WIDTH+3:0]           man_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   result,
  output logic                           flag_ovf,
  output logic                           flag_unf,
  output logic                           flag_inexact
);

  localparam int MW = MAN_WIDTH + 4;
  localparam int RW = 1 + EXP_WIDTH + MAN_WIDTH;

  localparam logic [EXP_WIDTH:0] E_ZERO = '0;
  localparam logic [EXP_WIDTH:0] E_ONE  = {{EXP_WIDTH{1'b0}}, 1'b1};
  localparam logic [EXP_WIDTH:0] E_MAX  = {1'b0, {EXP_WIDTH{1'b1}}};
  localparam logic [MW-1:0]      M_ZERO = '0;
  localparam logic [MW-1:0]      M_RND  = {{(MW-3){1'b0}}, 3'b100};
  localparam logic [MW-1:0]      M_HID  = {2'b01, {(MAN_WIDTH+2){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [MW-1:0]       m_q, m_d;
  logic [EXP_WIDTH:0]  e_q, e_d;
  logic                sign_q, sign_d;
  logic [RW-1:0]       result_q, result_d;
  logic                flag_ovf_q, flag_ovf_d;
  logic                flag_unf_q, flag_unf_d;
  logic                flag_inexact_q, flag_inexact_d;

  logic [EXP_WIDTH:0]  e_inc, e_dec, e_fin;
  logic [MW-1:0]       m_rsh, m_lsh, m_sum, m_fin;
  logic                round_up;
  logic [RW-1:0]       inf_val;

  // Datapath helpers shared by the FSM branches
  assign e_inc    = e_q + E_ONE;
  assign e_dec    = e_q - E_ONE;
  // Right shift keeps the sticky bit sticky: the bit falling off is ORed in
  assign m_rsh    = {1'b0, m_q[MW-1:2], m_q[1] | m_q[0]};
  assign m_lsh    = {m_q[MW-2:0], 1'b0};
  assign round_up = m_q[1] & (m_q[0] | m_q[2]);
  assign m_sum    = m_q + (round_up ? M_RND : M_ZERO);
  assign inf_val  = {sign_q, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign result       = result_q;
  assign flag_ovf     = flag_ovf_q;
  assign flag_unf     = flag_unf_q;
  assign flag_inexact = flag_inexact_q;

  // Next-state and datapath updates for the normalize/round sequence
  always_comb begin
    state_d        = state_q;
    m_d            = m_q;
    e_d            = e_q;
    sign_d         = sign_q;
    result_d       = result_q;
    flag_ovf_d     = flag_ovf_q;
    flag_unf_d     = flag_unf_q;
    flag_inexact_d = flag_inexact_q;
    e_fin          = e_q;
    m_fin          = m_sum;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          m_d            = man_in;
          e_d            = {1'b0, exp_in};
          sign_d         = sign_in;
          flag_ovf_d     = 1'b0;
          flag_unf_d     = 1'b0;
          flag_inexact_d = 1'b0;
          state_d        = S_CHECK;
        end
      end

      S_CHECK: begin
        if (m_q == M_ZERO) begin
          result_d = '0;
          state_d  = S_DONE;
        end else if (e_q == E_MAX) begin
          result_d   = inf_val;
          flag_ovf_d = 1'b1;
          state_d    = S_DONE;
        end else if (m_q[MW-1]) begin
          if (e_inc == E_MAX) begin
            result_d   = inf_val;
            flag_ovf_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            m_d     = m_rsh;
            e_d     = e_inc;
            state_d = S_ROUND;
          end
        end else if (m_q[MW-2]) begin
          state_d = S_ROUND;
        end else if (e_q <= E_ONE) begin
          e_d     = E_ZERO;
          state_d = S_ROUND;
        end else begin
          state_d = S_SHIFT;
        end
      end

      // m is nonzero here, so the hidden bit is reached within MAN_WIDTH+2 shifts
      S_SHIFT: begin
        m_d = m_lsh;
        e_d = e_dec;
        if (m_lsh[MW-2]) begin
          state_d = S_ROUND;
        end else if (e_dec == E_ONE) begin
          e_d     = E_ZERO;
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        flag_inexact_d = m_q[1] | m_q[0];
        if (m_sum[MW-1]) begin
          m_fin = M_HID;
          e_fin = e_inc;
        end else if ((e_q == E_ZERO) && m_sum[MW-2]) begin
          e_fin = E_ONE;
        end
        m_d = m_fin;
        e_d = e_fin;
        if (e_fin >= E_MAX) begin
          result_d   = inf_val;
          flag_ovf_d = 1'b1;
        end else begin
          result_d   = {sign_q, e_fin[EXP_WIDTH-1:0], m_fin[MAN_WIDTH+1:2]};
          flag_unf_d = (e_fin == E_ZERO) && (m_fin != M_ZERO);
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and working registers, cleared by the async reset
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q        <= S_IDLE;
      m_q            <= '0;
      e_q            <= '0;
      sign_q         <= 1'b0;
      result_q       <= '0;
      flag_ovf_q     <= 1'b0;
      flag_unf_q     <= 1'b0;
      flag_inexact_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      m_q            <= m_d;
      e_q            <= e_d;
      sign_q         <= sign_d;
      result_q       <= result_d;
      flag_ovf_q     <= flag_ovf_d;
      flag_unf_q     <= flag_unf_d;
      flag_inexact_q <= flag_inexact_d;
    end
  end

endmodule

// File: tb/tb_normalize_round.sv
// Directed bench for normalize_round: hand-computed vectors covering carry,
// cancellation, zero, RNE ties, overflow, denormals, back-pressure and reset.
module tb_normalize_round;

  logic        clk;
  logic        arst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [26:0] man_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inexact;

  int checks   = 0;
  int failures = 0;

  normalize_round #(.EXP_WIDTH(8), .MAN_WIDTH(23)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sign_in      (sign_in),
    .exp_in       (exp_in),
    .man_in       (man_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flag_ovf     (flag_ovf),
    .flag_unf     (flag_unf),
    .flag_inexact (flag_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Issue one operand, measure latency to out_valid (cycles after the
  // accept cycle T), check result and {ovf,unf,inexact}, then pop it.
  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [26:0] m, input int lat,
                        input logic [31:0] res, input logic [2:0] flg,
                        input logic pop);
    int cyc;
    @(negedge clk);
    sign_in  = s;
    exp_in   = e;
    man_in   = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sign_in  = ~s;
    exp_in   = 8'hFF;
    man_in   = ~m;
    cyc = 1;
    while (cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) break;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_res"}, result, res);
    chk({tag, "_flg"}, {29'd0, flag_ovf, flag_unf, flag_inexact}, {29'd0, flg});
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
    if (pop) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_pop"}, {30'd0, in_ready, out_valid}, 32'd2);
    end
  endtask

  initial begin
    arst_n    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign_in   = 1'b0;
    exp_in    = 8'd0;
    man_in    = 27'd0;
    #13;
    chk("rst_rdy", {30'd0, in_ready, out_valid}, 32'd2);
    chk("rst_res", result, 32'h0);
    chk("rst_flg", {29'd0, flag_ovf, flag_unf, flag_inexact}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    run_op("carry",    1'b0, 8'd127, 27'h4000000,  3, 32'h40000000, 3'b000, 1'b1);
    run_op("cancel",   1'b0, 8'd127, 27'h0000004, 26, 32'h34000000, 3'b000, 1'b1);
    run_op("zero",     1'b1, 8'd100, 27'h0000000,  2, 32'h00000000, 3'b000, 1'b1);
    run_op("tie_up",   1'b0, 8'd127, 27'h3FFFFFE,  3, 32'h40000000, 3'b001, 1'b1);
    run_op("tie_even", 1'b0, 8'd127, 27'h3FFFFFA,  3, 32'h3FFFFFFE, 3'b001, 1'b1);
    run_op("ovf",      1'b0, 8'd254, 27'h4000000,  2, 32'h7F800000, 3'b100, 1'b1);
    run_op("inf_in",   1'b1, 8'd255, 27'h2000000,  2, 32'hFF800000, 3'b100, 1'b1);
    run_op("rnd_up",   1'b0, 8'd127, 27'h2000007,  3, 32'h3F800002, 3'b001, 1'b1);
    run_op("sticky",   1'b1, 8'd127, 27'h4000001,  3, 32'hC0000000, 3'b001, 1'b1);
    run_op("promote",  1'b0, 8'd1,   27'h1FFFFFE,  3, 32'h00800000, 3'b001, 1'b1);
    run_op("denorm",   1'b0, 8'd3,   27'h0000400,  5, 32'h00000400, 3'b010, 1'b0);

    // Back-pressure: result held, new operands ignored while DONE
    in_valid = 1'b1;
    exp_in   = 8'd200;
    man_in   = 27'h4000000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold", {result[31:0]}, 32'h00000400);
      chk("hold_hs", {29'd0, in_ready, out_valid, flag_unf}, 32'd3);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold_pop", {30'd0, in_ready, out_valid}, 32'd2);

    // Reset during SHIFT aborts the operation
    @(negedge clk);
    sign_in  = 1'b0;
    exp_in   = 8'd127;
    man_in   = 27'h0000004;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst", {30'd0, in_ready, out_valid}, 32'd0);
    arst_n = 1'b0;
    #1;
    chk("mid_rst", {30'd0, in_ready, out_valid}, 32'd2);
    chk("mid_rst_res", result, 32'h0);
    @(negedge clk);
    arst_n = 1'b1;

    run_op("post_rst", 1'b0, 8'd127, 27'h4000000, 3, 32'h40000000, 3'b000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
